// File: rtl/seq_pkg.sv
// Shared definitions for the 8-entry test sequence (generator and checker).
package seq_pkg;
  localparam int SEQ_LEN = 8;

  // Element i lives at SEQ_TABLE[i]; first element AF is index 0.
  localparam logic [SEQ_LEN-1:0][7:0] SEQ_TABLE = {
    8'h8D, 8'h0B, 8'hE2, 8'hFF, 8'h78, 8'hE2, 8'hBC, 8'hAF
  };

  typedef enum logic {SEARCH, LOCKED} state_t;

  function automatic logic [7:0] seq_at(input logic [2:0] idx);
    return SEQ_TABLE[idx];
  endfunction
endpackage

// File: rtl/seq_pair_lookup.sv
// Combinational search for (prev, data) among the 8 consecutive table pairs; idx is data's position.
module seq_pair_lookup
  import seq_pkg::*;
(
  input  logic [7:0] prev,
  input  logic [7:0] data,
  output logic       hit,
  output logic [2:0] idx
);
  always_comb begin
    hit = 1'b0;
    idx = 3'd0;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (prev == seq_at(3'(i)) && data == seq_at(3'(i + 1))) begin
        hit = 1'b1;
        idx = 3'(i + 1);
      end
    end
  end
endmodule

// File: rtl/sequence_checker.sv
// Locks onto the generator's 8-entry sequence, then verifies every valid sample and counts errors.
// Optional match counter enabled by SEQUENCE_CHECKER_MATCH_COUNT_EN.
module sequence_checker
  import seq_pkg::*;
#(
  parameter int ERR_W      = 8,
  parameter int MISS_LIMIT = 3
`ifdef SEQUENCE_CHECKER_MATCH_COUNT_EN
  ,
  parameter int CNT_W      = 16
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             valid,
  input  logic [7:0]       data,
  input  logic             clear,
  output logic             locked,
  output logic             mismatch,
  output logic [2:0]       exp_idx,
  output logic [ERR_W-1:0] error_count
`ifdef SEQUENCE_CHECKER_MATCH_COUNT_EN
  ,
  output logic [CNT_W-1:0] match_count
`endif
);
  state_t           state_q;
  logic [7:0]       prev_q;
  logic             prev_vld_q;
  logic [3:0]       miss_run_q;
  logic [2:0]       exp_idx_q;
  logic             mismatch_q;
  logic [ERR_W-1:0] error_count_q, error_count_d;

  logic       pair_hit;
  logic [2:0] pair_idx;
  logic       exp_hit;
  logic       err_inc;

  seq_pair_lookup u_lookup (
    .prev (prev_q),
    .data (data),
    .hit  (pair_hit),
    .idx  (pair_idx)
  );

  assign exp_hit = (data == seq_at(exp_idx_q));
  assign err_inc = valid && (state_q == LOCKED) && !exp_hit;

  always_comb begin
    error_count_d = error_count_q;
    if (clear)
      error_count_d = '0;
    else if (err_inc && error_count_q != '1)
      error_count_d = error_count_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= SEARCH;
      prev_q        <= 8'h00;
      prev_vld_q    <= 1'b0;
      miss_run_q    <= 4'd0;
      exp_idx_q     <= 3'd0;
      mismatch_q    <= 1'b0;
      error_count_q <= '0;
    end else begin
      mismatch_q    <= 1'b0;
      error_count_q <= error_count_d;
      if (valid) begin
        case (state_q)
          SEARCH: begin
            prev_q     <= data;
            prev_vld_q <= 1'b1;
            if (prev_vld_q && pair_hit) begin
              state_q    <= LOCKED;
              exp_idx_q  <= pair_idx + 3'd1;
              miss_run_q <= 4'd0;
            end
          end
          LOCKED: begin
            // A bad sample counts as corrupted data, so the index still advances.
            exp_idx_q <= exp_idx_q + 3'd1;
            if (exp_hit) begin
              miss_run_q <= 4'd0;
            end else begin
              mismatch_q <= 1'b1;
              miss_run_q <= miss_run_q + 4'd1;
              if (miss_run_q + 4'd1 == 4'(MISS_LIMIT)) begin
                state_q    <= SEARCH;
                prev_q     <= data;
                prev_vld_q <= 1'b1;
                miss_run_q <= 4'd0;
              end
            end
          end
          default: state_q <= SEARCH;
        endcase
      end
    end
  end

`ifdef SEQUENCE_CHECKER_MATCH_COUNT_EN
  logic [CNT_W-1:0] match_count_q, match_count_d;

  always_comb begin
    match_count_d = match_count_q;
    if (clear)
      match_count_d = '0;
    else if (valid && state_q == LOCKED && exp_hit)
      match_count_d = match_count_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) match_count_q <= '0;
    else       match_count_q <= match_count_d;
  end

  assign match_count = match_count_q;
`endif

  assign locked      = (state_q == LOCKED);
  assign mismatch    = mismatch_q;
  assign exp_idx     = exp_idx_q;
  assign error_count = error_count_q;
endmodule

// File: doc/sequence_checker.md
# sequence_checker

Stream checker that sits directly downstream of the sequence generator. It consumes the 8-bit generator output together with a per-sample valid strobe and acquires lock on the fixed 8-entry sequence AF, BC, E2, 78, FF, E2, 0B, 8D. Once locked, it verifies every following sample, counts errors and drops lock after repeated misses. It gives on-chip self-test of the generator path without a testbench model.

## Interface
- ERR_W, 8: width of the saturating error counter.
- MISS_LIMIT, 3: consecutive mismatches in LOCKED that force a return to SEARCH; legal range 1..15.
- CNT_W, 16: width of the match counter (present only with the configuration macro).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- valid  in  1  data carries a new sequence element this cycle. Integration: the generator's enable delayed by one clock.
- data  in  8  sample from the sequence generator.
- clear  in  1  synchronous clear of counters only.
- locked  out  1  checker is aligned to the sequence.
- mismatch  out  1  one-cycle pulse per failed comparison.
- exp_idx  out  3  table index expected at the next valid sample; meaningful only while locked.
- error_count  out  ERR_W  saturating count of mismatches.
- match_count  out  CNT_W  wrapping count of matches (SEQUENCE_CHECKER_MATCH_COUNT_EN only).

## Operation
- Reset values: locked=0, mismatch=0, exp_idx=0, error_count=0, match_count=0, state=SEARCH, prev_valid=0, miss_run=0.
- Cycles with valid=0: all state holds, and mismatch drops to 0.
- SEARCH:
  - On valid, store the sample in prev and set prev_valid=1.
  - If prev_valid was already 1 and (prev, data) is one of the 8 consecutive table pairs, go to LOCKED. Set exp_idx = (index of data + 1) mod 8 and miss_run=0.
  - All 8 pairs are unique, so the duplicate E2 resolves unambiguously (E2→78 is index 3; E2→0B is index 6).
  - No mismatch reporting in SEARCH.
- LOCKED, on each valid sample:
  - Compare data with table[exp_idx]. exp_idx always advances mod 8 on the valid sample, whether or not it matches; a bad sample is treated as corrupted, not as a slip.
  - Match: miss_run=0, match_count+1.
  - Mismatch: mismatch=1 for one cycle, error_count+1 (saturates at all-ones), miss_run+1.
  - When miss_run reaches MISS_LIMIT: go to SEARCH, locked=0, prev=data, prev_valid=1. This allows re-lock on the very next valid sample.
- clear=1:
  - Zeros error_count and match_count.
  - Takes priority over an increment in the same cycle.
  - Does not affect state, exp_idx or locked.
- Wrap-around: exp_idx 7→0. match_count wraps; error_count never wraps.

## Timing
- All outputs are registered. Latency is 1 clock from the sampling edge.
- locked rises on the edge that samples the second element of the acquiring pair.
- mismatch is high exactly during the cycle following the edge that sampled the bad data.
- With back-to-back valid samples, throughput is one comparison per clock.
- Simultaneous events:
  - Mismatch and the MISS_LIMIT exit in the same cycle: mismatch still pulses, and locked falls on that same edge.
  - valid and clear in the same cycle: the counter reads 0 afterward.
- Reset asserted mid-operation clears all outputs asynchronously. After reset deassertion, at least 2 valid samples are needed to lock.

## Configuration
- SEQUENCE_CHECKER_MATCH_COUNT_EN defined: the match_count port and its CNT_W counter are present.
- Undefined: no match_count port, no counter logic; all other behaviour is identical.

## Structure
- Shared package seq_pkg holds:
  - SEQ_LEN=8.
  - The 8-entry sequence table constant, shared with the generator.
  - The state enum {SEARCH, LOCKED}.
- Sub-module seq_pair_lookup: combinational. Inputs prev and data; outputs hit and the 3-bit index of data within the table. Used only in SEARCH.

## Test plan
- Reset, then valid samples AF, BC -> locked=1 one clock after the BC edge, exp_idx=2, error_count=0.
- Lock, then 16 consecutive correct samples -> mismatch never asserts; exp_idx wraps 7→0 twice; match_count=16 (macro on).
- Locked at exp_idx=4, inject 00 instead of FF, then continue with E2 -> single mismatch pulse, error_count=1, locked stays 1, exp_idx=6 after E2.
- Locked, feed 3 wrong samples with MISS_LIMIT=3, then send E2 followed by 0B -> three mismatch pulses, locked falls on the third, and re-locks on 0B with exp_idx=7.
- Start-up on the duplicate value: feed FF, E2, 0B -> locked after E2 with exp_idx=6; the 0B sample matches.
- Assert clear together with a mismatching valid sample, then assert reset while locked -> error_count=0 after clear; reset zeros locked and exp_idx immediately, without waiting for a clock.
